// File: rtl/shift_pkg.sv
// Shared shifter-datapath definitions: select polarity and assembler FSM states.
package shift_pkg;

   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StFull  = 2'd2
   } assembler_state_e;

endpackage

// File: rtl/shift_word_assembler.sv
// Reassembles serial bits from the shifter into parallel words, with a two-deep
// buffer (assembly register + output register) so the next word can fill while one waits.
module shift_word_assembler
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in_i,
   input  logic             bit_valid_i,
   output logic             bit_ready_o,
   input  logic             select_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] word_out_o,
   output logic             word_valid_o,
   input  logic             word_ready_i,
   output logic [CNT_W-1:0] bit_count_o
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(WIDTH);

   assembler_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] asm_q, asm_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             dir_q, dir_d;
   logic             ready_q;

   logic             pop;
   logic             accept;
   logic             dir_eff;
   logic [WIDTH-1:0] asm_shift;

   assign pop     = valid_q & word_ready_i;
   assign accept  = bit_valid_i & ready_q & ~flush_i;
   // Direction is taken live on the first bit of a word, then held.
   assign dir_eff = (state_q == StIdle) ? select_i : dir_q;
   assign asm_shift = (dir_eff == SHIFT_LEFT) ? {asm_q[WIDTH-2:0], bit_in_i}
                                              : {bit_in_i, asm_q[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      dir_d   = dir_q;
      word_d  = word_q;
      valid_d = valid_q & ~pop;
      unique case (state_q)
         StIdle, StShift: begin
            if (flush_i) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else if (accept) begin
               asm_d = asm_shift;
               if (state_q == StIdle) begin
                  dir_d = select_i;
               end
               if (cnt_q == LastCnt) begin
                  if (!valid_q || pop) begin
                     word_d  = asm_shift;
                     valid_d = 1'b1;
                     cnt_d   = '0;
                     state_d = StIdle;
                  end else begin
                     cnt_d   = FullCnt;
                     state_d = StFull;
                  end
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = StShift;
               end
            end
         end
         StFull: begin
            if (pop) begin
               word_d  = asm_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         dir_q   <= SHIFT_LEFT;
         ready_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         ready_q <= (state_d != StFull);
      end
   end

   // Outputs
   always_comb begin
      bit_ready_o  = ready_q;
      word_out_o   = word_q;
      word_valid_o = valid_q;
      bit_count_o  = cnt_q;
   end

endmodule
